// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
// Sequencer and arbiter in front of a byte-wide SPI shift engine. It shares
// the engine between single-byte CPU writes and multi-byte DMA blocks, runs
// DMA blocks byte by byte (fetch, exchange, optional store) and drives the
// card chip-select. The engine has no busy flag, so completion of every byte
// is tracked with a local down-counter started on the engine start strobe.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cs_we, cs_d, cs_n         chip-select register write / value / pin (active-low)
//   cpu_wr, cpu_wdata         CPU byte write strobe and data
//   cpu_busy, cpu_rdata       CPU byte pending or in flight / last received byte
//   dma_go, dma_len, dma_dir  DMA block start, length (0 = 2^LEN_W), direction
//   dma_active, dma_done      DMA in progress / 1-clock completion pulse
//   mem_rd_req/ack/data       memory fetch handshake (DMA memory->SPI)
//   mem_wr_req/ack/data       memory store handshake (DMA SPI->memory)
//   spi_cpu_req/din           engine CPU request and byte
//   spi_dma_req/din           engine DMA request and byte
//   spi_start, spi_dout       engine start strobe and received byte
module spi_xfer_ctrl #(
  parameter int BYTE_CLKS = 17,
  parameter int LEN_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_we,
  input  logic             cs_d,
  output logic             cs_n,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_busy,
  output logic [7:0]       cpu_rdata,
  input  logic             dma_go,
  input  logic [LEN_W-1:0] dma_len,
  input  logic             dma_dir,
  output logic             dma_active,
  output logic             dma_done,
  output logic             mem_rd_req,
  input  logic             mem_rd_ack,
  input  logic [7:0]       mem_rd_data,
  output logic             mem_wr_req,
  input  logic             mem_wr_ack,
  output logic [7:0]       mem_wr_data,
  output logic             spi_cpu_req,
  output logic [7:0]       spi_cpu_din,
  output logic             spi_dma_req,
  output logic [7:0]       spi_dma_din,
  input  logic             spi_start,
  input  logic [7:0]       spi_dout
);

  localparam int TMR_W = $clog2(BYTE_CLKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_XFER,
    CPU_WAIT,
    DMA_FETCH,
    DMA_SEND,
    DMA_WAIT,
    DMA_STORE,
    DMA_NEXT
  } state_t;

  state_t           state, state_next;
  logic             cs_reg;
  logic             pending;
  logic [7:0]       cpu_byte;
  logic             dir_reg;
  logic [LEN_W:0]   remaining;
  logic [7:0]       tx_byte;
  logic [TMR_W-1:0] timer;
  logic             waiting;
  logic             expiry;
  logic             start_seen;

  // Timer runs only in the two wait states; it expires when it reaches 0,
  // which is BYTE_CLKS clocks after the start strobe was seen.
  assign waiting    = (state == CPU_WAIT) || (state == DMA_WAIT);
  assign expiry     = waiting && (timer == '0);
  assign start_seen = spi_start && ((state == CPU_XFER) || (state == DMA_SEND));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // A pending CPU byte wins over a simultaneous DMA start.
        if (pending)     state_next = CPU_XFER;
        else if (dma_go) state_next = DMA_FETCH;
      end
      CPU_XFER:  if (spi_start) state_next = CPU_WAIT;
      CPU_WAIT:  if (expiry)    state_next = IDLE;
      DMA_FETCH: if (dir_reg || mem_rd_ack) state_next = DMA_SEND;
      DMA_SEND:  if (spi_start) state_next = DMA_WAIT;
      DMA_WAIT:  if (expiry)    state_next = dir_reg ? DMA_STORE : DMA_NEXT;
      DMA_STORE: if (mem_wr_ack) state_next = DMA_NEXT;
      DMA_NEXT:  state_next = (remaining == 1) ? IDLE : DMA_FETCH;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cs_n        = !cs_reg;
    cpu_busy    = pending || (state == CPU_XFER) || (state == CPU_WAIT);
    spi_cpu_req = (state == CPU_XFER);
    spi_cpu_din = (state == CPU_XFER) ? cpu_byte : 8'h00;
    spi_dma_req = (state == DMA_SEND);
    spi_dma_din = (state == DMA_SEND) ? tx_byte : 8'h00;
    mem_rd_req  = (state == DMA_FETCH) && !dir_reg;
    mem_wr_req  = (state == DMA_STORE);
    dma_done    = (state == DMA_NEXT) && (remaining == 1);
    dma_active  = (state == DMA_FETCH) || (state == DMA_SEND) ||
                  (state == DMA_WAIT)  || (state == DMA_STORE) ||
                  (state == DMA_NEXT);
  end

  // Byte timer: loaded on the start strobe, counted down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (start_seen) begin
      timer <= TMR_W'(BYTE_CLKS - 1);
    end else if (waiting && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

  // Chip-select register and the CPU pending latch. A new CPU byte is only
  // accepted while nothing is pending or in flight, so a clear and a set of
  // pending never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_reg   <= 1'b0;
      pending  <= 1'b0;
      cpu_byte <= 8'h00;
    end else begin
      if (cs_we) cs_reg <= cs_d;
      if ((state == CPU_WAIT) && expiry) begin
        pending <= 1'b0;
      end else if (cpu_wr && !cpu_busy) begin
        pending  <= 1'b1;
        cpu_byte <= cpu_wdata;
      end
    end
  end

  // DMA datapath: block setup, transmit byte selection, received-byte
  // capture and byte countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata   <= 8'hFF;
      dir_reg     <= 1'b0;
      remaining   <= '0;
      tx_byte     <= 8'h00;
      mem_wr_data <= 8'h00;
    end else begin
      if (expiry) cpu_rdata <= spi_dout;
      if ((state == IDLE) && !pending && dma_go) begin
        dir_reg   <= dma_dir;
        remaining <= (dma_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, dma_len};
      end
      if (state == DMA_FETCH) begin
        if (dir_reg)         tx_byte <= 8'hFF;
        else if (mem_rd_ack) tx_byte <= mem_rd_data;
      end
      if ((state == DMA_WAIT) && expiry && dir_reg) mem_wr_data <= spi_dout;
      if (state == DMA_NEXT) remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Testbench for spi_xfer_ctrl. Models the SPI engine (start strobe in the
// same clock as a request, received byte valid exactly BYTE_CLKS clocks
// later, garbage before) and a memory with configurable ack latency.
module tb_spi_xfer_ctrl;

  localparam int BYTE_CLKS = 17;
  localparam int LEN_W     = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cs_we = 1'b0, cs_d = 1'b0, cs_n;
  logic             cpu_wr = 1'b0;
  logic [7:0]       cpu_wdata = 8'h00;
  logic             cpu_busy;
  logic [7:0]       cpu_rdata;
  logic             dma_go = 1'b0;
  logic [LEN_W-1:0] dma_len = '0;
  logic             dma_dir = 1'b0;
  logic             dma_active, dma_done;
  logic             mem_rd_req, mem_rd_ack = 1'b0;
  logic [7:0]       mem_rd_data = 8'h00;
  logic             mem_wr_req, mem_wr_ack = 1'b0;
  logic [7:0]       mem_wr_data;
  logic             spi_cpu_req, spi_dma_req;
  logic [7:0]       spi_cpu_din, spi_dma_din;
  logic             spi_start = 1'b0;
  logic [7:0]       spi_dout = 8'h00;

  int total = 0;
  int bad   = 0;

  int start_cnt = 0, done_cnt = 0, wr_req_cycles = 0, excl_err = 0;
  int eng_age = -1;
  logic [7:0] eng_byte;
  logic [7:0] start_din_q[$];
  int         start_done_q[$];
  int         ack_start_q[$];
  logic [7:0] wr_log[$];
  logic [7:0] rd_q[$];
  logic [7:0] miso_q[$];
  int rd_delay = 2, wr_delay = 0, rd_wait = 0, wr_wait = 0;

  spi_xfer_ctrl #(.BYTE_CLKS(BYTE_CLKS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cs_we(cs_we), .cs_d(cs_d), .cs_n(cs_n),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
    .dma_go(dma_go), .dma_len(dma_len), .dma_dir(dma_dir),
    .dma_active(dma_active), .dma_done(dma_done),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_data(mem_wr_data),
    .spi_cpu_req(spi_cpu_req), .spi_cpu_din(spi_cpu_din),
    .spi_dma_req(spi_dma_req), .spi_dma_din(spi_dma_din),
    .spi_start(spi_start), .spi_dout(spi_dout)
  );

  always #5 clk = ~clk;

  // Engine model plus activity monitor.
  always @(negedge clk) begin
    spi_start = 1'b0;
    if (eng_age >= 0) begin
      eng_age++;
      if (eng_age == BYTE_CLKS) begin
        spi_dout = eng_byte;
        eng_age  = -1;
      end
    end
    if (spi_cpu_req && spi_dma_req) excl_err++;
    if (!rst && (spi_cpu_req || spi_dma_req)) begin
      spi_start = 1'b1;
      eng_age   = 0;
      spi_dout  = 8'hEE;
      if (spi_cpu_req) begin
        eng_byte = spi_cpu_din;
        start_din_q.push_back(spi_cpu_din);
      end else begin
        if (miso_q.size() > 0) eng_byte = miso_q.pop_front();
        else                   eng_byte = spi_dma_din;
        start_din_q.push_back(spi_dma_din);
      end
      start_done_q.push_back(done_cnt);
      start_cnt++;
    end
    if (dma_done) done_cnt++;
    if (mem_wr_req) wr_req_cycles++;
  end

  // Memory model.
  always @(negedge clk) begin
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    if (rst) begin
      rd_wait = 0;
      wr_wait = 0;
    end else begin
      if (mem_rd_req) begin
        if (rd_wait >= rd_delay) begin
          mem_rd_ack = 1'b1;
          if (rd_q.size() > 0) mem_rd_data = rd_q.pop_front();
          else                 mem_rd_data = 8'h00;
          rd_wait = 0;
        end else rd_wait++;
      end
      if (mem_wr_req) begin
        if (wr_wait >= wr_delay) begin
          mem_wr_ack = 1'b1;
          wr_log.push_back(mem_wr_data);
          ack_start_q.push_back(start_cnt);
          wr_wait = 0;
        end else wr_wait++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_din_q.delete();
    start_done_q.delete();
    ack_start_q.delete();
    wr_log.delete();
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if ({cs_n, cpu_busy, dma_active, dma_done, spi_cpu_req, spi_dma_req, mem_rd_req, mem_wr_req} !== 8'b1000_0000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=10000000", {cs_n, cpu_busy, dma_active, dma_done, spi_cpu_req, spi_dma_req, mem_rd_req, mem_wr_req}); end
    total++; if (cpu_rdata !== 8'hFF) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=ff", cpu_rdata); end
    total++; if ({mem_wr_data, spi_cpu_din, spi_dma_din} !== 24'h0) begin
      bad++; $display("[TB] FAIL reset_data got=%h want=000000", {mem_wr_data, spi_cpu_din, spi_dma_din}); end
    cs_we = 1'b1; cs_d = 1'b1;
    tick();
    total++; if (cs_n !== 1'b1) begin bad++; $display("[TB] FAIL cs_in_reset got=%b want=1", cs_n); end
    rst = 1'b0;
    tick();
    total++; if (cs_n !== 1'b0) begin bad++; $display("[TB] FAIL cs_after_write got=%b want=0", cs_n); end
    cs_we = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    int s0, n0, busy;
    bit req_seen;
    s0 = start_cnt; n0 = start_din_q.size(); busy = 0; req_seen = 1'b0;
    cpu_wdata = 8'hA5; cpu_wr = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      cpu_wr    = (k == 3);
      cpu_wdata = (k == 3) ? 8'h3C : 8'hA5;
      if (cpu_busy) busy++;
      if (k == 2) req_seen = spi_cpu_req;
    end
    cpu_wr = 1'b0;
    total++; if (req_seen !== 1'b1) begin bad++; $display("[TB] FAIL cpu_req got=%b want=1", req_seen); end
    total++; if (busy != BYTE_CLKS + 2) begin bad++; $display("[TB] FAIL cpu_busy_len got=%0d want=%0d", busy, BYTE_CLKS + 2); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("[TB] FAIL cpu_starts got=%0d want=1", start_cnt - s0); end
    total++; if (start_din_q.size() > n0 && start_din_q[n0] !== 8'hA5 || start_din_q.size() <= n0) begin
      bad++; $display("[TB] FAIL cpu_din got=%0d entries want=a5", start_din_q.size() - n0); end
    total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("[TB] FAIL cpu_rdata got=%h want=a5", cpu_rdata); end
  endtask

  task automatic test_dma_read();
    int s0, d0, w0;
    bit ok;
    clear_logs();
    s0 = start_cnt; d0 = done_cnt; w0 = wr_req_cycles;
    rd_q = '{8'h11, 8'h22, 8'h33}; rd_delay = 2;
    dma_go = 1'b1; dma_len = 9'd3; dma_dir = 1'b0;
    tick();
    dma_go = 1'b0;
    total++; if (dma_active !== 1'b1) begin bad++; $display("[TB] FAIL rd_active got=%b want=1", dma_active); end
    wait_done(d0, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rd_timeout got=0 want=1"); end
    repeat (3) tick();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("[TB] FAIL rd_done got=%0d want=1", done_cnt - d0); end
    total++; if (start_cnt - s0 != 3) begin bad++; $display("[TB] FAIL rd_starts got=%0d want=3", start_cnt - s0); end
    total++; if (start_din_q.size() != 3 || start_din_q[0] !== 8'h11 || start_din_q[1] !== 8'h22 || start_din_q[2] !== 8'h33) begin
      bad++; $display("[TB] FAIL rd_din got=%p want=11,22,33", start_din_q); end
    total++; if (wr_req_cycles != w0) begin bad++; $display("[TB] FAIL rd_no_store got=%0d want=%0d", wr_req_cycles, w0); end
    total++; if (dma_active !== 1'b0) begin bad++; $display("[TB] FAIL rd_active_end got=%b want=0", dma_active); end
    total++; if (cpu_rdata !== 8'h33) begin bad++; $display("[TB] FAIL rd_rdata got=%h want=33", cpu_rdata); end
  endtask

  task automatic test_dma_write();
    int s0, d0, w0;
    bit ok;
    clear_logs();
    s0 = start_cnt; d0 = done_cnt; w0 = wr_req_cycles;
    miso_q = '{8'h5A, 8'hC3}; wr_delay = 5;
    dma_go = 1'b1; dma_len = 9'd2; dma_dir = 1'b1;
    tick();
    dma_go = 1'b0;
    wait_done(d0, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL wr_timeout got=0 want=1"); end
    repeat (3) tick();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("[TB] FAIL wr_done got=%0d want=1", done_cnt - d0); end
    total++; if (start_din_q.size() != 2 || start_din_q[0] !== 8'hFF || start_din_q[1] !== 8'hFF) begin
      bad++; $display("[TB] FAIL wr_din got=%p want=ff,ff", start_din_q); end
    total++; if (wr_log.size() != 2 || wr_log[0] !== 8'h5A || wr_log[1] !== 8'hC3) begin
      bad++; $display("[TB] FAIL wr_data got=%p want=5a,c3", wr_log); end
    total++; if (wr_req_cycles - w0 != 12) begin bad++; $display("[TB] FAIL wr_stall got=%0d want=12", wr_req_cycles - w0); end
    total++; if (ack_start_q.size() < 1 || ack_start_q[0] != s0 + 1) begin
      bad++; $display("[TB] FAIL wr_order got=%p want=%0d", ack_start_q, s0 + 1); end
    total++; if (cpu_rdata !== 8'hC3) begin bad++; $display("[TB] FAIL wr_rdata got=%h want=c3", cpu_rdata); end
  endtask

  task automatic test_zero_len();
    int s0, d0;
    bit ok;
    clear_logs();
    s0 = start_cnt; d0 = done_cnt; wr_delay = 0;
    dma_go = 1'b1; dma_len = 9'd0; dma_dir = 1'b1;
    tick();
    dma_go = 1'b0;
    wait_done(d0, 15000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL zl_timeout got=0 want=1"); end
    repeat (3) tick();
    total++; if (start_cnt - s0 != 512) begin bad++; $display("[TB] FAIL zl_starts got=%0d want=512", start_cnt - s0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("[TB] FAIL zl_done got=%0d want=1", done_cnt - d0); end
    total++; if (wr_log.size() != 512) begin bad++; $display("[TB] FAIL zl_stores got=%0d want=512", wr_log.size()); end
  endtask

  task automatic test_back_to_back();
    int d0;
    bit ok;
    clear_logs();
    d0 = done_cnt;
    rd_q = '{8'h01, 8'h02}; rd_delay = 2;
    dma_go = 1'b1; dma_len = 9'd2; dma_dir = 1'b0;
    tick();
    dma_go = 1'b0;
    repeat (10) tick();
    cpu_wr = 1'b1; cpu_wdata = 8'h42;
    tick();
    cpu_wr = 1'b0;
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pending got=%b want=1", cpu_busy); end
    wait_done(d0, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_timeout got=0 want=1"); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!cpu_busy) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_cpu_timeout got=0 want=1"); end
    total++; if (start_din_q.size() != 3 || start_din_q[0] !== 8'h01 || start_din_q[1] !== 8'h02 || start_din_q[2] !== 8'h42) begin
      bad++; $display("[TB] FAIL b2b_order got=%p want=01,02,42", start_din_q); end
    total++; if (start_done_q.size() != 3 || start_done_q[1] != d0 || start_done_q[2] != d0 + 1) begin
      bad++; $display("[TB] FAIL b2b_after_done got=%p want=%0d,%0d", start_done_q, d0, d0 + 1); end
    total++; if (cpu_rdata !== 8'h42) begin bad++; $display("[TB] FAIL b2b_rdata got=%h want=42", cpu_rdata); end
  endtask

  task automatic test_reset_mid_dma();
    int d0, s1;
    clear_logs();
    rd_q = '{8'h07, 8'h08, 8'h09}; rd_delay = 2;
    dma_go = 1'b1; dma_len = 9'd3; dma_dir = 1'b0;
    tick();
    dma_go = 1'b0;
    repeat (6) tick();
    cpu_wr = 1'b1; cpu_wdata = 8'h55;
    tick();
    cpu_wr = 1'b0;
    repeat (4) tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    total++; if ({cs_n, cpu_busy, dma_active, dma_done, spi_cpu_req, spi_dma_req, mem_rd_req, mem_wr_req} !== 8'b1000_0000) begin
      bad++; $display("[TB] FAIL rst_mid_flags got=%b want=10000000", {cs_n, cpu_busy, dma_active, dma_done, spi_cpu_req, spi_dma_req, mem_rd_req, mem_wr_req}); end
    total++; if ({cpu_rdata, mem_wr_data} !== 16'hFF00) begin
      bad++; $display("[TB] FAIL rst_mid_data got=%h want=ff00", {cpu_rdata, mem_wr_data}); end
    tick();
    rst = 1'b0;
    s1 = start_cnt;
    repeat (60) tick();
    total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL rst_no_done got=%0d want=%0d", done_cnt, d0); end
    total++; if (start_cnt != s1) begin bad++; $display("[TB] FAIL rst_no_start got=%0d want=%0d", start_cnt, s1); end
    total++; if ({dma_active, cpu_busy} !== 2'b00) begin bad++; $display("[TB] FAIL rst_idle got=%b want=00", {dma_active, cpu_busy}); end
    rd_q.delete();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_dma_write();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_dma();
    total++; if (excl_err != 0) begin bad++; $display("[TB] FAIL req_exclusive got=%0d want=0", excl_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Sequencer and arbiter in front of the byte-wide SPI shift engine.
- Shares the engine between single-byte CPU writes and multi-byte DMA blocks, and drives the card chip-select.
- Runs DMA blocks byte by byte: memory fetch, SPI exchange, optional store of the received byte.
- Tracks per-byte completion with its own timer, because the engine exposes no busy flag.

Parameters:
- BYTE_CLKS, 17: clocks from engine start strobe until engine dout holds the exchanged byte.
- LEN_W, 9: DMA length width; a length of 0 means 2^LEN_W bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cs_we  in  1  chip-select register write strobe
- cs_d  in  1  chip-select value (1 = card selected)
- cs_n  out  1  card chip-select, active-low
- cpu_wr  in  1  CPU data-port write strobe, 1 clock
- cpu_wdata  in  8  CPU byte to send
- cpu_busy  out  1  CPU byte pending or in flight
- cpu_rdata  out  8  last byte received by any exchange
- dma_go  in  1  DMA block start strobe
- dma_len  in  LEN_W  byte count
- dma_dir  in  1  0 = memory->SPI (rx discarded); 1 = SPI->memory (tx 0xFF)
- dma_active  out  1  DMA block in progress
- dma_done  out  1  1-clock pulse after the last byte completes
- mem_rd_req  out  1  fetch request, held until acked
- mem_rd_ack  in  1  fetch data valid this clock
- mem_rd_data  in  8  fetched byte
- mem_wr_req  out  1  store request, held until acked
- mem_wr_ack  in  1  store accepted
- mem_wr_data  out  8  byte to store
- spi_cpu_req  out  1  to engine cpu_req
- spi_cpu_din  out  8  to engine cpu_din
- spi_dma_req  out  1  to engine dma_req
- spi_dma_din  out  8  to engine dma_din
- spi_start  in  1  engine start strobe
- spi_dout  in  8  engine received byte

Behaviour:
- Reset values: cs_n=1, cpu_busy=0, cpu_rdata=0xFF, dma_active=0, dma_done=0, all req=0, data outputs=0, state IDLE, pending clear.
- Reset mid-operation aborts everything immediately. No dma_done is issued. The engine finishes its own byte harmlessly.
- Chip-select:
  - cs_n = !cs_reg.
  - cs_we updates cs_reg in any state, next clock.
  - DMA never touches cs_reg.
- CPU pending latch:
  - cpu_wr when no byte is pending and no CPU byte is in flight latches cpu_wdata and sets pending.
  - cpu_wr while cpu_busy=1 is ignored.
  - cpu_busy = pending OR state CPU_XFER.
- State IDLE, priority when both are present: pending CPU byte first, then dma_go. A dma_go arriving while not IDLE is ignored.
- State CPU_XFER:
  - spi_cpu_req=1, spi_cpu_din=latched byte, until spi_start is seen.
  - Then the byte timer loads BYTE_CLKS-1 and counts down.
  - At 0: cpu_rdata<=spi_dout, clear pending, return to IDLE.
- State DMA_FETCH (entered from dma_go):
  - Entry: latch dma_len into remaining (0 -> 2^LEN_W), dma_active=1.
  - dir=0: assert mem_rd_req until mem_rd_ack, capture mem_rd_data, go to DMA_SEND.
  - dir=1: skip the fetch, tx byte = 0xFF, go to DMA_SEND.
- State DMA_SEND: spi_dma_req=1, spi_dma_din=tx byte, until spi_start, then go to DMA_WAIT. spi_cpu_req is never asserted simultaneously.
- State DMA_WAIT:
  - Byte timer as in CPU_XFER. At expiry cpu_rdata<=spi_dout.
  - dir=1 goes to DMA_STORE with mem_wr_data=spi_dout.
  - dir=0 goes to DMA_NEXT.
- State DMA_STORE: hold mem_wr_req until mem_wr_ack, then go to DMA_NEXT.
- State DMA_NEXT: decrement remaining.
  - If remaining was 1: dma_done=1 for 1 clock, dma_active=0, go to IDLE.
  - Otherwise go to DMA_FETCH.
- A CPU write during DMA is latched and issued after the block; it never interleaves.
- Engine requests are never asserted outside CPU_XFER/DMA_SEND. spi_start observed in any other state is ignored.
- Back-to-back minimum: the next engine request is asserted no earlier than the clock after the timer expiry.

Test Plan:
- Reset, then cs_we with cs_d=1 -> cs_n=1 during reset, cs_n=0 one clock after the write.
- cpu_wr 0xA5 in IDLE, loopback MISO=MOSI -> spi_cpu_req until start. cpu_busy for BYTE_CLKS+2 clocks. cpu_rdata=0xA5. A second cpu_wr while busy is ignored.
- dma_dir=0, len=3, memory returns 0x11,0x22,0x33 with 2-clock ack delay -> three spi_dma_req bursts with matching din, one dma_done pulse after byte 3, no mem_wr_req.
- dma_dir=1, len=2, MISO returns 0x5A then 0xC3, mem_wr_ack stalled 5 clocks -> din=0xFF each byte. mem_wr_data 0x5A then 0xC3. Next byte not started until ack.
- dma_len=0 with dir=1 -> exactly 512 exchanges, then dma_done.
- cpu_wr 0x42 mid-DMA; rst asserted mid-block in a separate run -> 0x42 exchanged only after dma_done. After rst, all outputs return to reset values with no dma_done.
